// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions used by the fetch path: FSM states, reset PC
// and the word-address increment helper.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  // Word addressing: the next sequential fetch is one word on, wrapping at 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; a synchronous
// flush empties it and takes priority over a simultaneous push.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop & (count_r != {(AW+1){1'b0}});
  assign do_push_s = push & ((count_r != DEPTH_C) | do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request at a time, responses queued
// for decode, redirects flush the queue and drop any in-flight response.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic [31:0] target_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  fetch_state_t state_r, state_nx_s;
  logic [31:0]  pc_r, pc_nx_s;
  logic [31:0]  resp_addr_r, resp_addr_nx_s;
  logic         discard_r, discard_nx_s;
  logic         imem_req_r;

  logic [63:0]   head_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   occ_s;
  logic          outstanding_s;
  logic          room_s;
  logic          push_s;
  logic          pop_s;

  assign outstanding_s = (state_r == RESP);
  assign occ_s         = {1'b0, fifo_count_s} + (CW+1)'(outstanding_s);
  // A redirect empties the buffer at this edge, so room is guaranteed.
  assign room_s        = pc_src | (occ_s < DEPTH_C);
  assign push_s        = outstanding_s & imem_rvalid & ~discard_r & ~pc_src;
  assign pop_s         = ~fifo_empty_s & if_ready;

  // Next-state, fetch PC and discard-flag computation.
  always_comb begin
    state_nx_s     = state_r;
    pc_nx_s        = pc_r;
    resp_addr_nx_s = resp_addr_r;
    discard_nx_s   = discard_r;
    case (state_r)
      IDLE: begin
        if (room_s) begin
          state_nx_s = REQ;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          state_nx_s     = RESP;
          resp_addr_nx_s = pc_r;
          pc_nx_s        = pc_next(pc_r);
          discard_nx_s   = 1'b0;
        end else begin
          state_nx_s = REQ;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          discard_nx_s = 1'b0;
          state_nx_s   = room_s ? REQ : IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    // Redirect: any response still owed to us (incl. one granted now) is stale.
    if (pc_src) begin
      pc_nx_s = target_address;
      if (((state_r == REQ) && imem_gnt) || ((state_r == RESP) && !imem_rvalid)) begin
        discard_nx_s = 1'b1;
      end else begin
        discard_nx_s = discard_nx_s;
      end
    end else begin
      pc_nx_s = pc_nx_s;
    end
  end

  // Fetch state registers and registered request strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      resp_addr_r <= 32'h0000_0000;
      discard_r   <= 1'b0;
      imem_req_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      resp_addr_r <= resp_addr_nx_s;
      discard_r   <= discard_nx_s;
      imem_req_r  <= (state_nx_s == REQ);
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (pc_src),
    .push      (push_s),
    .push_data ({resp_addr_r, imem_rdata}),
    .pop       (pop_s),
    .head_data (head_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign if_valid  = ~fifo_empty_s;
  assign if_pc     = head_s[63:32];
  assign if_instr  = head_s[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, checked
// against a reference model of the fetched instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          BD     = 2;

  logic        clk;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] target_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(BD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .target_address (target_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model and expected-stream model
  bit          m_pend, m_disc;
  logic [31:0] m_addr;
  int          m_lat, lat_min, lat_max;
  int          occ;
  logic [31:0] fetch_exp, exp_pc;
  int          n_grant, n_xfer;
  logic [31:0] g_prev, g_last, last_xfer_pc;
  bit          saw_rv, saw_xfer;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a falling edge with inputs already set.
  task automatic step();
    logic grant, xfer, rv, push;
    rv          = m_pend && (m_lat == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(m_addr) : $urandom();
    #1;
    grant = imem_req & imem_gnt;
    xfer  = if_valid & if_ready;
    check("if_valid_vs_model", 32'(if_valid), 32'(occ != 0));
    if (grant) begin
      check("grant_addr", imem_addr, fetch_exp);
      check("single_outstanding", 32'(m_pend), 32'd0);
    end
    if (xfer) begin
      check("if_pc", if_pc, exp_pc);
      check("if_instr", if_instr, mem_word(exp_pc));
    end
    push = rv && !m_disc && !pc_src;
    if (pc_src) occ = 0;
    else        occ = occ + (push ? 1 : 0) - (xfer ? 1 : 0);
    if (rv) begin
      m_pend = 1'b0;
      m_disc = 1'b0;
    end else if (m_pend) begin
      if (pc_src) m_disc = 1'b1;
      if (m_lat > 0) m_lat--;
    end
    if (grant) begin
      m_pend    = 1'b1;
      m_addr    = imem_addr;
      m_lat     = $urandom_range(lat_max, lat_min);
      m_disc    = pc_src;
      g_prev    = g_last;
      g_last    = imem_addr;
      n_grant++;
      fetch_exp = fetch_exp + 32'd1;
    end
    if (xfer) begin
      last_xfer_pc = if_pc;
      n_xfer++;
      exp_pc = exp_pc + 32'd1;
    end
    if (pc_src) begin
      fetch_exp = target_address;
      exp_pc    = target_address;
    end
    saw_rv   = rv;
    saw_xfer = xfer;
    @(posedge clk);
    @(negedge clk);
    pc_src      = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    pc_src      = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    m_pend = 1'b0; m_disc = 1'b0; occ = 0;
    fetch_exp = RST_PC; exp_pc = RST_PC;
    rst_n = 1'b1;
  endtask

  initial begin
    int g0, x0;
    bit found;
    rst_n = 1'b0; pc_src = 1'b0; target_address = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; if_ready = 1'b0;
    lat_min = 0; lat_max = 0; n_grant = 0; n_xfer = 0;
    g_prev = 32'd0; g_last = 32'd0; last_xfer_pc = 32'd0;

    // Reset and sequential fetch at single-cycle latency
    apply_reset();
    check("idle_after_release", 32'(imem_req), 32'd0);
    imem_gnt = 1'b1; if_ready = 1'b1;
    step();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RST_PC);
    repeat (10) step();
    g0 = n_grant; x0 = n_xfer;
    repeat (20) step();
    check("throughput_grants", 32'(n_grant - g0), 32'd10);
    check("throughput_xfers", 32'(n_xfer - x0), 32'd10);

    // Backpressure: fill, stall fetching, then drain exactly BD entries
    if_ready = 1'b0;
    repeat (20) step();
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(if_valid), 32'd1);
    imem_gnt = 1'b0; if_ready = 1'b1; x0 = n_xfer;
    repeat (6) step();
    check("drain_count", 32'(n_xfer - x0), 32'(BD));
    imem_gnt = 1'b1;
    repeat (20) step();

    // Reset while a response is outstanding, then a stray response
    lat_min = 3; lat_max = 3; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_pend) begin found = 1'b1; break; end
      step();
    end
    check("find_pending_for_reset", 32'(found), 32'd1);
    apply_reset();
    m_pend = 1'b1; m_lat = 0; m_disc = 1'b1; m_addr = 32'hDEAD_0000;
    imem_gnt = 1'b1; if_ready = 1'b1;
    step();
    check("stray_ignored", 32'(if_valid), 32'd0);
    check("post_reset_req", 32'(imem_req), 32'd1);
    check("post_reset_addr", imem_addr, RST_PC);

    // Redirect to 0x40 while address 5 is outstanding
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (m_pend && m_addr == 32'd5) begin found = 1'b1; break; end
      step();
    end
    check("find_pending_addr5", 32'(found), 32'd1);
    pc_src = 1'b1; target_address = 32'h40;
    step();
    for (int i = 0; i < 10; i++) begin
      if (saw_rv) break;
      step();
    end
    check("redirect_req", 32'(imem_req), 32'd1);
    check("redirect_addr", imem_addr, 32'h40);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (saw_xfer) begin found = 1'b1; break; end
    end
    check("redirect_first_xfer_seen", 32'(found), 32'd1);
    check("redirect_first_if_pc", last_xfer_pc, 32'h40);

    // Redirect coinciding with a response and a decode transfer
    lat_min = 0; lat_max = 0;
    repeat (10) step();
    if_ready = 1'b0; found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_valid && m_pend && m_lat == 0) begin found = 1'b1; break; end
      step();
    end
    check("find_simultaneous", 32'(found), 32'd1);
    if_ready = 1'b1; pc_src = 1'b1; target_address = 32'h100;
    step();
    check("simul_xfer", 32'(saw_xfer), 32'd1);
    check("simul_rvalid", 32'(saw_rv), 32'd1);
    check("simul_empty", 32'(if_valid), 32'd0);
    repeat (10) step();

    // Wrap-around of the fetch PC
    lat_min = 0; lat_max = 1;
    pc_src = 1'b1; target_address = 32'hFFFF_FFFF;
    step();
    g0 = n_grant;
    for (int i = 0; i < 20; i++) begin
      if (n_grant >= g0 + 2) break;
      step();
    end
    check("wrap_first", g_prev, 32'hFFFF_FFFF);
    check("wrap_second", g_last, 32'h0000_0000);

    // Randomized traffic
    lat_min = 0; lat_max = 2;
    for (int i = 0; i < 1500; i++) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      if_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        pc_src = 1'b1;
        target_address = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom();
      end
      step();
    end
    check("random_progress", 32'(n_xfer > 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
